// File: rtl/stream_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
package stream_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Ceiling log2, never below 1 so derived widths stay legal.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/stream_rr_arbiter_if.sv
// Merge-side bundle: NUM_IN upstream val/ready streams, one tagged downstream stream, stall counter.
interface stream_rr_arbiter_if #(
  parameter int NUM_IN     = 4,
  parameter int DATA_WIDTH = 32
);
  import stream_arb_pkg::*;

  localparam int IDX_W = clog2(NUM_IN);

  logic [NUM_IN*DATA_WIDTH-1:0] din;
  logic [NUM_IN-1:0]            val_in;
  logic [NUM_IN-1:0]            ready_upward;
  logic [IDX_W+DATA_WIDTH-1:0]  dout;
  logic                         val_out;
  logic                         ready_downward;
  logic                         cnt_clr;
  logic                         state_in;
  logic [31:0]                  out_stall_cnt;

  modport master (
    output din, val_in, ready_downward, cnt_clr, state_in,
    input  ready_upward, dout, val_out, out_stall_cnt
  );

  modport slave (
    input  din, val_in, ready_downward, cnt_clr, state_in,
    output ready_upward, dout, val_out, out_stall_cnt
  );

endinterface

// File: rtl/stream_rr_pick.sv
// Round-robin priority encoder: first requester strictly after i_rr_ptr, with wrap-around,
// found on a doubled request vector so no modulo mux chain is needed.
module stream_rr_pick
  import stream_arb_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int IDX_W  = 2
) (
  input  logic [NUM_IN-1:0] i_req,
  input  logic [IDX_W-1:0]  i_rr_ptr,
  output logic              o_any_req,
  output logic [IDX_W-1:0]  o_pick
);

  logic [2*NUM_IN-1:0] w_dreq;
  logic [2*NUM_IN-1:0] w_mask;
  logic [2*NUM_IN-1:0] w_hit;
  logic [IDX_W:0]      w_first;

  assign w_dreq    = {i_req, i_req};
  assign w_hit     = w_dreq & w_mask;
  assign o_any_req = |i_req;

  // Window of NUM_IN positions starting just above the pointer.
  always_comb begin
    w_mask = '0;
    for (int j = 0; j < 2*NUM_IN; j++) begin
      w_mask[j] = (j > int'(i_rr_ptr)) && (j <= int'(i_rr_ptr) + NUM_IN);
    end
  end

  always_comb begin
    w_first = '0;
    for (int j = 2*NUM_IN-1; j >= 0; j--) begin
      if (w_hit[j]) begin
        w_first = (IDX_W+1)'(j);
      end else begin
        w_first = w_first;
      end
    end
  end

  always_comb begin
    if (w_first >= (IDX_W+1)'(NUM_IN)) begin
      o_pick = IDX_W'(w_first - (IDX_W+1)'(NUM_IN));
    end else begin
      o_pick = w_first[IDX_W-1:0];
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Burst-locked round-robin merge of NUM_IN streams into one registered, source-tagged stream
// with a downstream backpressure counter.
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter int NUM_IN     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4
) (
  input  logic              clk,
  input  logic              reset,
  stream_rr_arbiter_if.slave bus
);

  localparam int IDX_W = clog2(NUM_IN);
  localparam int BC_W  = clog2(BURST_LEN + 1);

  arb_state_e                  r_state;
  logic [IDX_W-1:0]            r_rr_ptr;
  logic [IDX_W-1:0]            r_grant;
  logic [BC_W-1:0]             r_beat_cnt;
  logic [IDX_W+DATA_WIDTH-1:0] r_dout;
  logic                        r_val_out;
  logic [31:0]                 r_stall_cnt;

  logic                        w_can_load;
  logic                        w_any_req;
  logic [IDX_W-1:0]            w_pick;
  logic [IDX_W-1:0]            w_sel;
  logic                        w_load;
  logic [NUM_IN-1:0]           w_ready_up;
  logic [DATA_WIDTH-1:0]       w_sel_data;
  logic [BC_W-1:0]             w_beat_nxt;

  stream_rr_pick #(
    .NUM_IN (NUM_IN),
    .IDX_W  (IDX_W)
  ) u_pick (
    .i_req     (bus.val_in),
    .i_rr_ptr  (r_rr_ptr),
    .o_any_req (w_any_req),
    .o_pick    (w_pick)
  );

  assign w_can_load = !r_val_out || bus.ready_downward;
  assign w_sel_data = bus.din[w_sel*DATA_WIDTH +: DATA_WIDTH];
  assign w_beat_nxt = r_beat_cnt + BC_W'(1);

  assign bus.ready_upward  = w_ready_up;
  assign bus.dout          = r_dout;
  assign bus.val_out       = r_val_out;
  assign bus.out_stall_cnt = r_stall_cnt;

  // Per-port ready and transfer decision; IDLE picks combinationally so bursts chain without a bubble.
  always_comb begin
    w_ready_up = '0;
    w_load     = 1'b0;
    w_sel      = r_grant;
    case (r_state)
      IDLE: begin
        if (w_any_req && w_can_load) begin
          w_sel              = w_pick;
          w_ready_up[w_pick] = 1'b1;
          w_load             = 1'b1;
        end else begin
          w_load = 1'b0;
        end
      end
      GRANT: begin
        w_ready_up[r_grant] = w_can_load;
        w_load              = w_can_load && bus.val_in[r_grant];
      end
      default: begin
        w_load = 1'b0;
      end
    endcase
  end

  // Output register, grant FSM and stall counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rr_ptr    <= IDX_W'(NUM_IN - 1);
      r_grant     <= '0;
      r_beat_cnt  <= '0;
      r_dout      <= '0;
      r_val_out   <= 1'b0;
      r_stall_cnt <= 32'd0;
    end else begin
      if (w_can_load) begin
        r_val_out <= w_load;
        if (w_load) begin
          r_dout <= {w_sel, w_sel_data};
        end
      end

      if (bus.cnt_clr) begin
        r_stall_cnt <= 32'd0;
      end else if (r_val_out && !bus.ready_downward && !bus.state_in) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end

      case (r_state)
        IDLE: begin
          if (w_load) begin
            r_grant    <= w_pick;
            r_beat_cnt <= BC_W'(1);
            if (BURST_LEN == 1) begin
              r_rr_ptr <= w_pick;
            end else begin
              r_state <= GRANT;
            end
          end
        end
        GRANT: begin
          if (w_load) begin
            r_beat_cnt <= w_beat_nxt;
            if (w_beat_nxt == BC_W'(BURST_LEN)) begin
              r_rr_ptr <= r_grant;
              r_state  <= IDLE;
            end
          end else if (w_can_load) begin
            // Granted port dropped valid: release early, the lost slot becomes one bubble.
            r_rr_ptr <= r_grant;
            r_state  <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Randomized scoreboard bench for stream_rr_arbiter: a transaction-level model predicts every
// accepted word, per-port ready, val_out and the stall counter.
module tb_stream_rr_arbiter;
  import stream_arb_pkg::*;

  localparam int NUM_IN     = 4;
  localparam int DATA_WIDTH = 32;
  localparam int BURST_LEN  = 4;
  localparam int IDX_W      = clog2(NUM_IN);
  localparam int OW         = IDX_W + DATA_WIDTH;

  logic clk;
  logic rst;

  stream_rr_arbiter_if #(.NUM_IN(NUM_IN), .DATA_WIDTH(DATA_WIDTH)) bus ();

  stream_rr_arbiter #(
    .NUM_IN     (NUM_IN),
    .DATA_WIDTH (DATA_WIDTH),
    .BURST_LEN  (BURST_LEN)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Sources: port i emits base[i] + seq for seq = 0 .. remaining words.
  logic [31:0] base[NUM_IN];
  int          next_seq[NUM_IN];
  int          remaining[NUM_IN];
  int          vprob[NUM_IN];
  int          rprob;
  logic        knob_state_in;
  logic        knob_clr;

  // Reference model state.
  bit          m_val_out;
  int          m_owner;
  int          m_beats;
  int          m_last;
  logic [31:0] m_stall;
  logic [OW-1:0] expq[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_val_out = 1'b0;
    m_owner   = -1;
    m_beats   = 0;
    m_last    = NUM_IN - 1;
    m_stall   = 32'd0;
    expq.delete();
  endtask

  task automatic load_port(input int p, input logic [31:0] b, input int n);
    base[p]      = b;
    next_seq[p]  = 0;
    remaining[p] = n;
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_IN; i++) begin
      bus.val_in[i] = (remaining[i] > 0) && ($urandom_range(99) < vprob[i]);
      bus.din[i*DATA_WIDTH +: DATA_WIDTH] = (remaining[i] > 0) ? base[i] + next_seq[i] : $urandom;
    end
    bus.ready_downward = ($urandom_range(99) < rprob);
    bus.state_in       = knob_state_in;
    bus.cnt_clr        = knob_clr;
  endtask

  // Apply the arbitration rules to the inputs of this cycle, compare, then advance one edge.
  task automatic model_step();
    logic [NUM_IN-1:0] exp_rdy;
    int  xfer;
    int  p;
    bit  can_load;
    can_load = !m_val_out || bus.ready_downward;
    exp_rdy  = '0;
    xfer     = -1;
    if (m_owner < 0) begin
      if (can_load) begin
        for (int k = 1; k <= NUM_IN; k++) begin
          p = (m_last + k) % NUM_IN;
          if (xfer < 0 && bus.val_in[p]) xfer = p;
        end
      end
      if (xfer >= 0) exp_rdy[xfer] = 1'b1;
    end else if (can_load) begin
      exp_rdy[m_owner] = 1'b1;
      if (bus.val_in[m_owner]) xfer = m_owner;
    end
    check("ready_upward", 64'(bus.ready_upward), 64'(exp_rdy));
    check("val_out", 64'(bus.val_out), 64'(m_val_out));
    check("out_stall_cnt", 64'(bus.out_stall_cnt), 64'(m_stall));

    if (bus.cnt_clr) m_stall = 32'd0;
    else if (m_val_out && !bus.ready_downward && !bus.state_in) m_stall = m_stall + 32'd1;

    if (xfer >= 0) begin
      expq.push_back({IDX_W'(xfer), base[xfer] + 32'(next_seq[xfer])});
      next_seq[xfer]++;
      remaining[xfer]--;
      if (m_owner < 0) begin
        m_beats = 1;
        if (BURST_LEN == 1) m_last = xfer;
        else m_owner = xfer;
      end else begin
        m_beats++;
        if (m_beats == BURST_LEN) begin
          m_last  = m_owner;
          m_owner = -1;
        end
      end
    end else if (m_owner >= 0 && can_load) begin
      m_last  = m_owner;
      m_owner = -1;
    end
    if (can_load) m_val_out = (xfer >= 0);
  endtask

  task automatic step_now();
    drive();
    #1;
    model_step();
  endtask

  task automatic cycle();
    @(negedge clk);
    step_now();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic set_vprob(input int v);
    for (int i = 0; i < NUM_IN; i++) vprob[i] = v;
  endtask

  // Asynchronous reset between edges: output must clear without waiting for the clock.
  task automatic mid_cycle_reset();
    #4;
    rst = 1'b1;
    #1;
    check("async_reset_val_out", 64'(bus.val_out), 64'd0);
    check("async_reset_dout", 64'(bus.dout), 64'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    step_now();
  endtask

  // Monitor: every handshake on the output must match the oldest predicted word.
  initial begin
    logic [OW-1:0] exp;
    forever begin
      @(negedge clk);
      #3;
      if (!rst && bus.val_out && bus.ready_downward) begin
        if (expq.size() == 0) begin
          check("dout_unexpected", 64'(bus.dout), 64'hDEAD);
        end else begin
          exp = expq.pop_front();
          check("dout", 64'(bus.dout), 64'(exp));
        end
      end
    end
  end

  initial begin
    int guard;
    int pending;
    rst           = 1'b1;
    knob_state_in = 1'b0;
    knob_clr      = 1'b0;
    rprob         = 100;
    set_vprob(0);
    for (int i = 0; i < NUM_IN; i++) load_port(i, 32'd0, 0);
    bus.din            = '0;
    bus.val_in         = '0;
    bus.ready_downward = 1'b1;
    bus.cnt_clr        = 1'b0;
    bus.state_in       = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_val_out", 64'(bus.val_out), 64'd0);
    check("reset_dout", 64'(bus.dout), 64'd0);
    check("reset_stall", 64'(bus.out_stall_cnt), 64'd0);
    rst = 1'b0;
    step_now();

    // Single port, bursts back to back.
    load_port(2, 32'hA0, 6);
    vprob[2] = 100;
    run(12);

    // All ports saturated, four beats each.
    for (int i = 0; i < NUM_IN; i++) load_port(i, 32'h100 * (i + 1), 4);
    set_vprob(100);
    run(22);

    // Downstream stall mid-burst.
    for (int i = 0; i < NUM_IN; i++) load_port(i, 32'h1000 * (i + 1), 8);
    run(3);
    rprob = 0;
    run(5);
    rprob = 100;
    run(40);

    // Early release of port 1 with port 3 waiting.
    set_vprob(0);
    load_port(1, 32'h2100, 2);
    load_port(3, 32'h2300, 4);
    vprob[1] = 100;
    vprob[3] = 100;
    run(12);

    // Reset mid-burst, then all ports valid again.
    for (int i = 0; i < NUM_IN; i++) load_port(i, 32'h3000 * (i + 1), 8);
    set_vprob(100);
    run(2);
    mid_cycle_reset();
    run(40);

    // Frozen counting, then clear coinciding with a stall.
    for (int i = 0; i < NUM_IN; i++) load_port(i, 32'h4000 * (i + 1), 8);
    run(3);
    rprob = 0;
    run(2);
    knob_state_in = 1'b1;
    run(3);
    knob_state_in = 1'b0;
    knob_clr      = 1'b1;
    run(1);
    knob_clr      = 1'b0;
    run(2);
    rprob = 100;
    run(40);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      if (c % 50 == 0) begin
        for (int i = 0; i < NUM_IN; i++) begin
          vprob[i] = $urandom_range(100);
          if (remaining[i] == 0) load_port(i, $urandom, $urandom_range(12));
        end
        rprob = $urandom_range(30, 100);
      end
      knob_clr      = ($urandom_range(99) < 2);
      knob_state_in = ($urandom_range(99) < 20);
      cycle();
    end

    // Drain with a bounded budget.
    knob_clr      = 1'b0;
    knob_state_in = 1'b0;
    rprob         = 100;
    set_vprob(100);
    guard = 0;
    pending = 1;
    while (pending != 0 && guard < 400) begin
      cycle();
      guard++;
      pending = expq.size();
      for (int i = 0; i < NUM_IN; i++) pending += remaining[i];
    end
    run(2);
    check("drain_queue_empty", 64'(expq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_rr_arbiter.md
Name: stream_rr_arbiter

Overview:
Round-robin arbiter that merges NUM_IN upstream stream_shell outputs into one downstream val/ready stream, such as a shared BFT leaf port or a shared operator input. Grants are burst-locked: a port holds the link for up to BURST_LEN beats, or until its val_in drops. Each output word is tagged with its source port index so the receiver can demultiplex. An output stall counter, gated by the same state/clear convention as the stream counters, exposes downstream backpressure for bottleneck analysis.

Parameters:
NUM_IN, 4, number of requesting streams (2..16)
DATA_WIDTH, 32, payload width per stream
BURST_LEN, 4, maximum beats per grant (>=1)
IDX_W, $clog2(NUM_IN), derived; width of the source tag

Ports:
clk  in  1  single clock
reset  in  1  asynchronous, active-high
din  in  NUM_IN*DATA_WIDTH  packed payloads; port i occupies [i*DATA_WIDTH +: DATA_WIDTH]
val_in  in  NUM_IN  per-port valid
ready_upward  out  NUM_IN  per-port ready, combinational
dout  out  IDX_W+DATA_WIDTH  registered {src_idx, payload}
val_out  out  1  registered valid
ready_downward  in  1  downstream ready
cnt_clr  in  1  synchronous clear of stall counter
state_in  in  1  when 1, counting is frozen
out_stall_cnt  out  32  cycles with val_out=1 and ready_downward=0

Behaviour:
- Reset (asynchronous) clears all state immediately: val_out=0, dout=0, state=IDLE, rr_ptr=NUM_IN-1 (so port 0 has first priority), beat_cnt=0, grant=0, out_stall_cnt=0. A word held in the output register during reset is discarded.
- Output register load condition: can_load = !val_out || ready_downward. A transfer takes place when the granted port has val_in=1, its ready_upward=1, and can_load=1. The transferred word appears on dout/val_out on the next cycle (1-cycle latency).
- If can_load=1 and no new word is loaded, val_out goes to 0 on the next edge. If can_load=0, dout and val_out hold.
- IDLE state:
  - If any val_in=1 and can_load=1: pick p = first port with val_in=1, searching (rr_ptr+1) mod NUM_IN upward with wrap-around.
  - Assert ready_upward[p] only, load the register, set grant=p, beat_cnt=1.
  - If BURST_LEN==1: set rr_ptr=p and stay in IDLE. Otherwise go to GRANT.
  - If can_load=0, all ready_upward=0.
- GRANT state:
  - ready_upward[grant] = can_load; every other bit is 0.
  - On a transfer, beat_cnt increments. If beat_cnt reaches BURST_LEN on that transfer: rr_ptr=grant, go to IDLE. IDLE re-arbitrates in the next cycle with no bubble, because the pick is combinational.
  - If val_in[grant]=0 while can_load=1 (early release): rr_ptr=grant, go to IDLE. No load occurs, so one bubble cycle results.
  - If val_in[grant]=0 and can_load=0: hold in GRANT.
- Requests from other ports never preempt an active grant.
- Payload order within a port is always preserved.
- out_stall_cnt:
  - cnt_clr=1 sets it to 0; cnt_clr has priority over counting.
  - Otherwise it increments when val_out && !ready_downward && !state_in.
  - It wraps modulo 2^32.
- beat_cnt width is $clog2(BURST_LEN+1). A grant count never exceeds BURST_LEN.

Decomposition:
- Shared package stream_arb_pkg holds:
  - state encoding IDLE=1'b0, GRANT=1'b1
  - helper function clog2
- One natural sub-module, stream_rr_pick: combinational round-robin priority encoder. Inputs are req[NUM_IN] and rr_ptr. Outputs are any_req and pick index. It is built as a double-width mask-and-find-first so wrap-around needs no loop-carried mux.

Test Plan:
1. NUM_IN=4, BURST_LEN=4, ready_downward=1. Only port 2 valid with data 0xA0..0xA5 -> dout = {2,0xA0..0xA3}, then re-grant of port 2 with {2,0xA4},{2,0xA5}. Order kept, val_out continuous, no bubble.
2. All four ports continuously valid, ready_downward=1 -> grant sequence 0,1,2,3,0, 4 beats each. 16 beats in 16 cycles. Tags 0000111122223333.
3. Mid-burst, ready_downward=0 for 5 cycles -> dout/val_out stable, all ready_upward=0, out_stall_cnt increases by 5. Burst resumes at the correct beat.
4. Port 1 granted, drops val_in after 2 beats while port 3 is valid -> one cycle with val_out=0, then port 3 granted (round-robin searches from 2).
5. Assert reset mid-burst of port 3 -> val_out=0 in the same cycle without a clock edge. After release, with all ports valid, first grant is port 0.
6. state_in=1 during a 3-cycle stall -> counter unchanged. Then cnt_clr=1 -> out_stall_cnt=0 next cycle, even if a stall coincides.
